// File: rtl/pdm_mic_receiver.sv
// rtl/pdm_mic_receiver.sv - PDM microphone clock generator, deserialiser and decimator
//
// Purpose:
//   Drives the PDM microphone clock, samples the 1-bit PDM stream on each
//   falling pdm_clk edge, counts ones over DECIM bits and emits a signed
//   32-bit PCM sample (2*ones - DECIM) through a valid/ready output register
//   with a sticky overrun flag.
//   Optional macro PDM_DC_BLOCK_EN: when defined, a first-order DC removal
//   stage (40-bit accumulator, 8 fractional bits) sits in front of the output
//   register and adds one cycle of latency.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   enable       run request, level-sensitive
//   pdm_data     microphone data, asynchronous to clk
//   pdm_clk      microphone clock
//   pdm_lrsel    channel select, tied 0
//   sample_data  signed PCM sample
//   sample_valid sample_data holds an unconsumed sample
//   sample_ready consumer accepts the sample when valid & ready
//   overrun      sticky flag: a completed sample overwrote an unconsumed one
//   clr_overrun  synchronous clear of overrun
`timescale 1ns/1ps

module pdm_mic_receiver #(
   parameter int CLK_DIV = 50,
   parameter int DECIM   = 64,
   parameter int SETTLE  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        pdm_data,
   output logic        pdm_clk,
   output logic        pdm_lrsel,
   output logic [31:0] sample_data,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        overrun,
   input  logic        clr_overrun
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int AW = $clog2(DECIM + 1);
   localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN} state_t;

   state_t        state, state_next;
   logic          sync1, sync2;
   logic [DW-1:0] div_cnt;
   logic [AW-1:0] ones_acc, bit_cnt, ones_next;
   logic [SW-1:0] settle_cnt;
   logic [31:0]   raw, raw_val;
   logic          done;
   logic          run, tc, capture, form;
   logic          load;
   logic [31:0]   load_data;

   assign pdm_lrsel = 1'b0;

   assign run       = (state != S_IDLE);
   assign tc        = run && (div_cnt == DW'(CLK_DIV - 1));
   // Falling pdm_clk edge: the bit the microphone presented is stable here.
   assign capture   = tc && pdm_clk;
   assign form      = capture && (bit_cnt == AW'(DECIM - 1));
   assign ones_next = ones_acc + {{(AW-1){1'b0}}, sync2};
   assign raw_val   = ({{(32-AW){1'b0}}, ones_next} << 1) - 32'(DECIM);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (enable) state_next = (SETTLE == 0) ? S_RUN : S_SETTLE;
         S_SETTLE: if (!enable) state_next = S_IDLE;
                   else if (form && settle_cnt == SW'(SETTLE - 1)) state_next = S_RUN;
         S_RUN:    if (!enable) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         div_cnt    <= '0;
         pdm_clk    <= 1'b0;
         ones_acc   <= '0;
         bit_cnt    <= '0;
         settle_cnt <= '0;
         raw        <= '0;
         done       <= 1'b0;
      end else begin
         sync1 <= pdm_data;
         sync2 <= sync1;
         // A sample completing while enable is already low belongs to the
         // aborted run and is never handed to the output register.
         done  <= form && (state == S_RUN) && enable;
         if (form) raw <= raw_val;
         if (!run) begin
            div_cnt    <= '0;
            pdm_clk    <= 1'b0;
            ones_acc   <= '0;
            bit_cnt    <= '0;
            settle_cnt <= '0;
         end else begin
            if (tc) begin
               div_cnt <= '0;
               pdm_clk <= ~pdm_clk;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
            if (capture) begin
               if (form) begin
                  ones_acc <= '0;
                  bit_cnt  <= '0;
                  if (state == S_SETTLE) settle_cnt <= settle_cnt + 1'b1;
               end else begin
                  ones_acc <= ones_next;
                  bit_cnt  <= bit_cnt + 1'b1;
               end
            end
         end
      end
   end

`ifdef PDM_DC_BLOCK_EN
   // dc is in 1/256 units; diff = x - dc in the same units, so diff >>> 8 is
   // both the integer output y and the accumulator step.
   logic [39:0] dc;
   logic [40:0] diff;
   logic [32:0] step;
   logic [31:0] dc_y, y_sat;
   logic        dc_done;

   assign diff  = {raw[31], raw, 8'b0} - {dc[39], dc};
   assign step  = diff[40:8];
   assign y_sat = (step[32] != step[31]) ? (step[32] ? 32'h8000_0000 : 32'h7fff_ffff)
                                         : step[31:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dc      <= '0;
         dc_y    <= '0;
         dc_done <= 1'b0;
      end else begin
         dc_done <= done;
         if (!run) dc <= '0;
         else if (done) dc <= dc + {{7{step[32]}}, step};
         if (done) dc_y <= y_sat;
      end
   end

   assign load      = dc_done;
   assign load_data = dc_y;
`else
   assign load      = done;
   assign load_data = raw;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sample_data  <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         // A new load beats a same-cycle handshake; an overrun event beats a clear.
         overrun <= (overrun && !clr_overrun) || (load && sample_valid && !sample_ready);
         if (load) begin
            sample_data  <= load_data;
            sample_valid <= 1'b1;
         end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pdm_mic_receiver.sv
// tb/tb_pdm_mic_receiver.sv - scoreboard testbench for pdm_mic_receiver
`timescale 1ns/1ps

module tb_pdm_mic_receiver;
   localparam int CLK_DIV = 2;
   localparam int DECIM   = 8;
   localparam int SETTLE  = 2;

   logic        clk = 1'b0, rst = 1'b0, enable = 1'b0, pdm_data = 1'b0;
   logic        sample_ready = 1'b1, clr_overrun = 1'b0;
   logic        pdm_clk, pdm_lrsel, sample_valid, overrun;
   logic [31:0] sample_data;

   int          checks = 0, passed = 0;
   int          cyc = 0;
   logic [31:0] sb_q[$];
   bit          sb_on = 1'b1;
   logic [3:0]  pat_bits = 4'b0000;
   int          pat_len = 1, pat_idx = 0;
   int          last_acc = -1, acc_gap = 0;
   time         pclk_last = 0, pclk_period = 0;

   pdm_mic_receiver #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .enable(enable), .pdm_data(pdm_data),
      .pdm_clk(pdm_clk), .pdm_lrsel(pdm_lrsel), .sample_data(sample_data),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .overrun(overrun), .clr_overrun(clr_overrun));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Microphone model: new bit after each falling pdm_clk edge.
   always @(negedge pdm_clk) begin
      pdm_data = pat_bits[pat_idx % pat_len];
      pat_idx  = pat_idx + 1;
   end

   always @(posedge pdm_clk) begin
      pclk_period = $time - pclk_last;
      pclk_last   = $time;
   end

   // Scoreboard: every handshake pops one expected sample.
   always @(negedge clk) begin
      if (rst && sample_valid && sample_ready) begin
         if (last_acc >= 0) acc_gap = cyc - last_acc;
         last_acc = cyc;
         if (sb_on) begin
            checks++;
            if (sb_q.size() == 0)
               $display("FAIL sb_unexpected got %h expected none", sample_data);
            else begin
               logic [31:0] exp_v;
               exp_v = sb_q.pop_front();
               if (sample_data !== exp_v) $display("FAIL sb_data got %h want %h", sample_data, exp_v);
               else passed++;
            end
         end
      end
   end

   task automatic set_pattern(input logic [3:0] bits, input int len);
      pat_bits = bits;
      pat_len  = len;
      pdm_data = bits[0];
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (!sample_valid && n < budget) begin
         @(posedge clk); n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_empty(input string name, input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
      checks++;
      if (sb_q.size() != 0) $display("FAIL %s_timeout got %0d pending want 0", name, sb_q.size());
      else passed++;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (pdm_clk !== 1'b0) $display("FAIL reset_pdm_clk got %b want 0", pdm_clk); else passed++;
      checks++; if (pdm_lrsel !== 1'b0) $display("FAIL reset_lrsel got %b want 0", pdm_lrsel); else passed++;
      checks++; if (sample_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", sample_valid); else passed++;
      checks++; if (sample_data !== 32'h0) $display("FAIL reset_data got %h want 0", sample_data); else passed++;
      checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
      rst = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++; if (pdm_clk !== 1'b0) $display("FAIL idle_pdm_clk got %b want 0", pdm_clk); else passed++;
      checks++; if (sample_valid !== 1'b0) $display("FAIL idle_valid got %b want 0", sample_valid); else passed++;
   endtask

   task automatic test_constant_one();
      int n;
      set_pattern(4'b1111, 1);
      repeat (3) sb_q.push_back(32'h0000_0008);
      @(negedge clk) enable = 1'b1;
      wait_valid(500, n);
      // Two settle samples of 32 cycles each, the third formed at cycle 96, loaded at 97.
      checks++; if (n !== 98) $display("FAIL first_sample_latency got %0d want 98", n); else passed++;
      wait_empty("const_one", 300);
      checks++; if (acc_gap !== 32) $display("FAIL sample_period got %0d want 32", acc_gap); else passed++;
      checks++; if (pclk_period !== 40) $display("FAIL pdm_clk_period got %0t want 40", pclk_period); else passed++;
      enable = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++; if (pdm_clk !== 1'b0) $display("FAIL disable_pdm_clk got %b want 0", pdm_clk); else passed++;
   endtask

   task automatic test_patterns();
      logic [3:0]  bits[3] = '{4'b0000, 4'b0101, 4'b0111};
      int          lens[3] = '{1, 2, 4};
      logic [31:0] exps[3] = '{32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0004};
      for (int i = 0; i < 3; i++) begin
         set_pattern(bits[i], lens[i]);
         repeat (2) sb_q.push_back(exps[i]);
         @(negedge clk) enable = 1'b1;
         wait_empty("pattern", 400);
         enable = 1'b0;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic test_overrun();
      int n;
      set_pattern(4'b0000, 1);
      @(posedge clk) #1 sample_ready = 1'b0;
      @(negedge clk) enable = 1'b1;
      wait_valid(500, n);
      repeat (100) @(posedge clk);
      @(negedge clk);
      checks++; if (sample_valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", sample_valid); else passed++;
      checks++; if (sample_data !== 32'hFFFF_FFF8) $display("FAIL ovr_data got %h want fffffff8", sample_data); else passed++;
      checks++; if (overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", overrun); else passed++;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      clr_overrun = 1'b1;
      @(negedge clk) clr_overrun = 1'b0;
      checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear got %b want 0", overrun); else passed++;
      checks++; if (sample_valid !== 1'b1) $display("FAIL ovr_hold_valid got %b want 1", sample_valid); else passed++;
      sb_q.push_back(32'hFFFF_FFF8);
      @(posedge clk) #1 sample_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (sample_valid !== 1'b0) $display("FAIL ovr_accept_valid got %b want 0", sample_valid); else passed++;
      checks++; if (sb_q.size() != 0) $display("FAIL ovr_accept_pop got %0d pending want 0", sb_q.size()); else passed++;
   endtask

   task automatic test_enable_drop();
      int  n, k;
      logic prev;
      set_pattern(4'b1111, 1);
      sb_q.push_back(32'h0000_0008);
      @(negedge clk) enable = 1'b1;
      wait_empty("drop_first", 400);
      k = 0; n = 0; prev = pdm_clk;
      while (k < 5 && n < 200) begin
         @(negedge clk); n++;
         if (prev && !pdm_clk) k++;
         prev = pdm_clk;
      end
      n = 0;
      while (!pdm_clk && n < 20) begin @(negedge clk); n++; end
      enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (pdm_clk !== 1'b0) $display("FAIL drop_pdm_clk got %b want 0", pdm_clk); else passed++;
      repeat (100) @(posedge clk);
      @(negedge clk);
      checks++; if (sample_valid !== 1'b0) $display("FAIL drop_no_sample got %b want 0", sample_valid); else passed++;
      set_pattern(4'b0000, 1);
      sb_q.push_back(32'hFFFF_FFF8);
      @(negedge clk) enable = 1'b1;
      wait_valid(500, n);
      checks++; if (n !== 98) $display("FAIL reenable_latency got %0d want 98", n); else passed++;
      wait_empty("reenable", 100);
      enable = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_async_reset();
      int n;
      set_pattern(4'b1111, 1);
      @(posedge clk) #1 sample_ready = 1'b0;
      @(negedge clk) enable = 1'b1;
      wait_valid(600, n);
      repeat (40) @(posedge clk);
      @(posedge clk) #3 rst = 1'b0;
      #1;
      checks++; if (pdm_clk !== 1'b0) $display("FAIL areset_pdm_clk got %b want 0", pdm_clk); else passed++;
      checks++; if (sample_valid !== 1'b0) $display("FAIL areset_valid got %b want 0", sample_valid); else passed++;
      checks++; if (sample_data !== 32'h0) $display("FAIL areset_data got %h want 0", sample_data); else passed++;
      checks++; if (overrun !== 1'b0) $display("FAIL areset_overrun got %b want 0", overrun); else passed++;
      enable = 1'b0;
      #13 rst = 1'b1;
      sample_ready = 1'b1;
      repeat (50) @(posedge clk);
      @(negedge clk);
      checks++; if (sample_valid !== 1'b0) $display("FAIL post_reset_valid got %b want 0", sample_valid); else passed++;
      checks++; if (pdm_clk !== 1'b0) $display("FAIL post_reset_pdm_clk got %b want 0", pdm_clk); else passed++;
      checks++; if (sample_data !== 32'h0) $display("FAIL post_reset_data got %h want 0", sample_data); else passed++;
   endtask

`ifdef PDM_DC_BLOCK_EN
   task automatic test_dc_block();
      logic signed [31:0] got[$];
      int n = 0;
      bit mono = 1'b1;
      sb_on = 1'b0;
      set_pattern(4'b1111, 1);
      @(negedge clk) enable = 1'b1;
      while (got.size() < 12 && n < 3000) begin
         @(negedge clk); n++;
         if (sample_valid && sample_ready) got.push_back(sample_data);
      end
      enable = 1'b0;
      checks++; if (got.size() != 12) $display("FAIL dc_count got %0d want 12", got.size()); else passed++;
      checks++;
      if (got.size() == 0 || got[0] !== 32'sd8) $display("FAIL dc_first got %h want 00000008", (got.size() != 0) ? got[0] : 32'hx);
      else passed++;
      for (int i = 1; i < got.size(); i++) if (got[i] > got[i-1] || got[i] < 0) mono = 1'b0;
      checks++; if (!mono) $display("FAIL dc_decay got non-monotonic want monotonic non-negative"); else passed++;
      repeat (4) @(negedge clk);
      sb_on = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
`ifdef PDM_DC_BLOCK_EN
      test_dc_block();
`else
      test_constant_one();
      test_patterns();
      test_overrun();
      test_enable_drop();
`endif
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
